// File: rtl/csr_sample_sequencer.sv
// csr_sample_sequencer
// Latches the sample count (N) and signal-enable mask (M) on an accepted start,
// then streams (sample index, signal id) work items over a valid/ready
// handshake: for each index 0..N-1 it visits every enabled signal in
// ascending id order. It reports busy, a one-cycle done pulse, and a sticky
// overrun flag.
// Optional build macro: CSR_SAMPLE_SEQ_CONTINUOUS_EN adds continuous_i. With
// continuous_i high at the last-item handshake, the run restarts from the
// first item with no bubble and pulses done_o for each completed pass.
module csr_sample_sequencer #(
  parameter int unsigned SAMPLES_WIDTH = 16,
  parameter int unsigned SIGNALS_WIDTH = 8,
  parameter int unsigned SIG_ID_WIDTH  = (SIGNALS_WIDTH > 1) ? $clog2(SIGNALS_WIDTH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [SAMPLES_WIDTH-1:0] samples_csr_i,
  input  logic [SIGNALS_WIDTH-1:0] signals_csr_i,
  input  logic                     start_i,
  input  logic                     abort_i,
`ifdef CSR_SAMPLE_SEQ_CONTINUOUS_EN
  input  logic                     continuous_i,
`endif
  output logic                     smp_valid_o,
  input  logic                     smp_ready_i,
  output logic [SAMPLES_WIDTH-1:0] smp_index_o,
  output logic [SIG_ID_WIDTH-1:0]  smp_signal_o,
  output logic                     smp_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overrun_o
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t                   state_q;
  logic [SAMPLES_WIDTH-1:0] n_q;
  logic [SIGNALS_WIDTH-1:0] m_q;
  logic [SAMPLES_WIDTH-1:0] index_q;
  logic [SIG_ID_WIDTH-1:0]  id_q;
  logic                     overrun_q;
  logic                     done_q;

  logic                     has_next;
  logic [SIG_ID_WIDTH-1:0]  next_id;
  logic [SIG_ID_WIDTH-1:0]  lo_m;
  logic [SIG_ID_WIDTH-1:0]  lo_csr;
  logic                     last_idx;
  logic                     hs;

  // Bit scans: next enabled id above the current one, and lowest enabled id
  // of the latched and incoming masks. Scanning downward lets the lowest
  // qualifying bit be the final assignment.
  always_comb begin
    has_next = 1'b0;
    next_id  = '0;
    lo_m     = '0;
    lo_csr   = '0;
    for (int unsigned i = SIGNALS_WIDTH; i > 0; i--) begin
      if (m_q[i-1] && ((i - 1) > 32'(id_q))) begin
        has_next = 1'b1;
        next_id  = SIG_ID_WIDTH'(i - 1);
      end
      if (m_q[i-1]) begin
        lo_m = SIG_ID_WIDTH'(i - 1);
      end
      if (signals_csr_i[i-1]) begin
        lo_csr = SIG_ID_WIDTH'(i - 1);
      end
    end
  end

  assign last_idx     = (index_q == (n_q - SAMPLES_WIDTH'(1)));
  assign smp_valid_o  = (state_q == S_EMIT);
  assign hs           = smp_valid_o && smp_ready_i;
  assign smp_index_o  = index_q;
  assign smp_signal_o = id_q;
  assign smp_last_o   = smp_valid_o && last_idx && !has_next;
  assign busy_o       = smp_valid_o;
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;

  // Sequencer state, latched CSRs, item pointer and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      m_q       <= '0;
      index_q   <= '0;
      id_q      <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_q       <= samples_csr_i;
            m_q       <= signals_csr_i;
            overrun_q <= 1'b0;
            if ((samples_csr_i == '0) || (signals_csr_i == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              index_q <= '0;
              id_q    <= lo_csr;
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (hs) begin
            if (has_next) begin
              id_q <= next_id;
            end else if (!last_idx) begin
              index_q <= index_q + SAMPLES_WIDTH'(1);
              id_q    <= lo_m;
            end
`ifdef CSR_SAMPLE_SEQ_CONTINUOUS_EN
            else if (continuous_i) begin
              index_q <= '0;
              id_q    <= lo_m;
              done_q  <= 1'b1;
            end
`endif
            else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          // Abort wins over completion: the item may still be consumed,
          // but no done pulse is produced.
          if (abort_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_sample_sequencer.md
Name: csr_sample_sequencer

Overview:
- Sits between the core's custom CSR outputs (samples_csr_o, signals_csr_o) and the XIF coprocessor's sample intake; it feeds the coprocessor.
- On a start pulse it latches the sample count and the signal-enable mask.
- It then emits a valid/ready stream of (sample index, signal id) work items: for each index it walks every enabled signal in ascending id order.
- It reports busy, done and overrun status.

Parameters:
- SAMPLES_WIDTH, 16, width of the sample-count CSR and of the index output.
- SIGNALS_WIDTH, 8, width of the signal-enable mask; bit k enables signal id k.
- SIG_ID_WIDTH, $clog2(SIGNALS_WIDTH) (min 1), width of the signal id output.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous active-low reset.
- samples_csr_i  input  SAMPLES_WIDTH  number of sample indices N; latched on an accepted start.
- signals_csr_i  input  SIGNALS_WIDTH  signal-enable mask M; latched on an accepted start.
- start_i  input  1  single-cycle start request.
- abort_i  input  1  abort the current run.
- smp_valid_o  output  1  work item valid.
- smp_ready_i  input  1  downstream accepts the item.
- smp_index_o  output  SAMPLES_WIDTH  current sample index.
- smp_signal_o  output  SIG_ID_WIDTH  current signal id.
- smp_last_o  output  1  final item of the run.
- busy_o  output  1  run in progress (state EMIT).
- done_o  output  1  one-cycle pulse at run completion.
- overrun_o  output  1  sticky: start_i seen while not IDLE.

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low. While in reset all outputs are 0, the state is IDLE, and the latched N, M, index and id are 0.
- States: IDLE, EMIT, DONE.
- IDLE with start_i=1 (accepted start):
  - Latch N and M, clear overrun_o.
  - If N==0 or M==0, go to DONE and emit no items.
  - Otherwise set index=0, set id = lowest set bit of M, go to EMIT.
  - smp_valid_o rises in the cycle after the start.
- EMIT:
  - smp_valid_o=1 and busy_o=1. Payload (index, id, last) is held stable until the handshake (smp_valid_o && smp_ready_i).
  - On handshake, if a set bit of M exists above id: id moves to the next set bit; index is unchanged.
  - Otherwise, if index < N-1: index increments and id wraps to the lowest set bit.
  - Otherwise (last item): go to DONE.
  - smp_last_o = (index==N-1) && (no set bit of M above id). It is combinational from state, asserted only with smp_valid_o.
  - With smp_ready_i held high, throughput is 1 item per cycle. The total item count is N × popcount(M).
- DONE: done_o=1 for exactly one cycle, smp_valid_o=0, then go to IDLE.
- start_i while in EMIT or DONE: ignored, overrun_o set to 1. overrun_o is sticky until the next accepted start.
- abort_i (any state other than IDLE):
  - Next state is IDLE; smp_valid_o drops the following cycle.
  - done_o is not pulsed on abort.
  - If abort_i coincides with a handshake, that item counts as consumed.
  - abort_i in IDLE has no effect.
  - abort_i and start_i together in IDLE: the start is accepted.
- CSR inputs changing mid-run have no effect; only the latched copies are used.
- Index arithmetic is unsigned SAMPLES_WIDTH. N = 2^SAMPLES_WIDTH-1 completes without wrap.

Optional Feature:
- Macro: CSR_SAMPLE_SEQ_CONTINUOUS_EN.
- When defined:
  - Adds port continuous_i (input, 1), sampled at the last-item handshake.
  - If continuous_i=1 at that handshake: done_o pulses in the cycle after the handshake, but the state stays EMIT. index restarts at 0 and id at the lowest set bit of M, so the next item is valid in the cycle after the handshake with no bubble.
  - smp_last_o still marks the final item of each pass.
  - Only abort_i, or continuous_i=0 at a last handshake, ends the run.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Basic run: N=3, M=8'b0000_0101, ready held high, start pulse → 6 items (0,0),(0,2),(1,0),(1,2),(2,0),(2,2) on consecutive cycles; smp_last_o only on (2,2); done_o pulses 1 cycle later; busy_o high for 6 cycles.
- Backpressure: N=2, M=8'h80, ready toggled 1/0 → payload stable while ready=0; items (0,7),(1,7) with last on (1,7); no items lost or duplicated.
- Degenerate inputs: N=0, M=8'hFF → no smp_valid_o, done_o pulses 1 cycle after start. Repeat with N=5, M=0 → same response.
- Overrun and CSR change: start during EMIT and change samples_csr_i mid-run → overrun_o=1, run continues with the original N. The next accepted start clears overrun_o.
- Abort with handshake: N=4, M=8'h03, abort_i asserted together with the handshake of the 3rd item → smp_valid_o=0 the next cycle, state IDLE, no done_o. A new start then begins from (0,0).
- Reset mid-run: assert rst_ni low while in EMIT → all outputs 0 asynchronously, IDLE after release. With CSR_SAMPLE_SEQ_CONTINUOUS_EN defined, N=1, M=1, continuous_i=1 → item (0,0) with last every cycle and done_o every cycle until abort.
